// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions for the scan controller and the sprite renderers.
// Contents:
//   - 640x480@60 default timing constants and total-period helper
//   - coord_t : 10-bit scan coordinate shared with the renderers
//   - rgb_t   : 12-bit colour {R[11:8],G[7:4],B[3:0]} with channel slice helpers
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned MAX_TOTAL = 1 << COORD_W;

    localparam int unsigned CLK_DIV_DEF   = 4;
    localparam int unsigned H_DISPLAY_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam int unsigned PIPE_LAT_DEF  = 2;
    localparam int unsigned PIPE_LAT_MAX  = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [11:0]        rgb_t;
    typedef logic [3:0]         chan_t;

    function automatic int unsigned calc_total(input int unsigned disp, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    function automatic chan_t rgb_red(input rgb_t c);
        return c[11:8];
    endfunction

    function automatic chan_t rgb_green(input rgb_t c);
        return c[7:4];
    endfunction

    function automatic chan_t rgb_blue(input rgb_t c);
        return c[3:0];
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-length shift register used to align sync/blank with renderer latency.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset, loads RESET_VAL into every stage
//   i_d     : input word, shifted in every clock
//   o_q     : input word delayed by DEPTH clocks (DEPTH = 0 passes i_d straight through)
module sync_delay_line #(
    parameter int unsigned       WIDTH     = 1,
    parameter int unsigned       DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = ^{i_clk, i_reset};
        assign o_q      = i_d;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= RESET_VAL;
                end
            end else begin
                r_stage[0] <= i_d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: generates pixel coordinates for the sprite renderers, takes back the
// composited colour and drives VGA sync/colour with sync delayed to match renderer latency.
// Ports:
//   system_clk : design clock
//   reset      : synchronous active-high reset
//   pixel_tick : one-cycle pulse every CLK_DIV clocks; coordinates advance on it
//   pixel_x/y  : current scan coordinates
//   video_on   : visible-area flag aligned to pixel_x/pixel_y (undelayed)
//   frame_tick : one-cycle pulse at the start of vertical blank
//   rgb_in     : composited colour from the renderers, valid PIPE_LAT clocks after a coordinate change
//   hsync/vsync: active-low sync, latency-aligned to colour
//   vga_red/green/blue : registered colour, forced to 0 outside the visible area
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
    parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic        system_clk,
    input  logic        reset,
    output logic        pixel_tick,
    output coord_t      pixel_x,
    output coord_t      pixel_y,
    output logic        video_on,
    output logic        frame_tick,
    input  rgb_t        rgb_in,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue
);

    localparam int unsigned H_TOTAL  = calc_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL  = calc_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_scan_ctrl: H_TOTAL/V_TOTAL exceed coordinate range");
    end
    if (PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_lat
        $error("vga_scan_ctrl: PIPE_LAT out of range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_scan_ctrl: CLK_DIV must be at least 1");
    end

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam coord_t           X_LAST     = coord_t'(H_TOTAL - 1);
    localparam coord_t           Y_LAST     = coord_t'(V_TOTAL - 1);
    localparam coord_t           Y_LAST_VIS = coord_t'(V_DISPLAY - 1);

    logic [DIV_W-1:0] r_div;
    coord_t           r_x;
    coord_t           r_y;
    logic             r_frame_tick;
    logic             r_hsync;
    logic             r_vsync;
    rgb_t             r_rgb;

    logic             w_pixel_tick;
    logic             w_line_end;
    logic             w_frame_end;
    logic [31:0]      w_x_ext;
    logic [31:0]      w_y_ext;
    logic             w_video_on;
    logic             w_hsync_raw;
    logic             w_vsync_raw;
    logic [2:0]       w_dly;

    assign w_pixel_tick = (r_div == DIV_LAST);
    assign w_line_end   = (r_x == X_LAST);
    assign w_frame_end  = (r_y == Y_LAST);

    // Widen before comparing so display/sync bounds equal to 1024 still compare correctly.
    assign w_x_ext     = {{(32-COORD_W){1'b0}}, r_x};
    assign w_y_ext     = {{(32-COORD_W){1'b0}}, r_y};
    assign w_video_on  = (w_x_ext < H_DISPLAY) && (w_y_ext < V_DISPLAY);
    assign w_hsync_raw = !((w_x_ext >= HS_START) && (w_x_ext < HS_END));
    assign w_vsync_raw = !((w_y_ext >= VS_START) && (w_y_ext < VS_END));

    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_div        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_div        <= w_pixel_tick ? '0 : r_div + 1'b1;
            // Pulse follows the tick that leaves the last visible pixel of the frame.
            r_frame_tick <= w_pixel_tick && w_line_end && (r_y == Y_LAST_VIS);
            if (w_pixel_tick) begin
                if (w_line_end) begin
                    r_x <= '0;
                    r_y <= w_frame_end ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // Delays sync/blank by the renderer latency so they line up with rgb_in.
    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_LAT),
        .RESET_VAL (3'b110)
    ) u_sync_dly (
        .i_clk   (system_clk),
        .i_reset (reset),
        .i_d     ({w_hsync_raw, w_vsync_raw, w_video_on}),
        .o_q     (w_dly)
    );

    always_ff @(posedge system_clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_dly[2];
            r_vsync <= w_dly[1];
            // Renderers may drive garbage/X outside their boxes; blanking masks it.
            r_rgb   <= w_dly[0] ? rgb_in : '0;
        end
    end

    assign pixel_tick = w_pixel_tick;
    assign pixel_x    = r_x;
    assign pixel_y    = r_y;
    assign video_on   = w_video_on;
    assign frame_tick = r_frame_tick;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign vga_red    = rgb_red(r_rgb);
    assign vga_green  = rgb_green(r_rgb);
    assign vga_blue   = rgb_blue(r_rgb);

endmodule
